// File: rtl/inst_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_cache_pkg
//  Description : Shared types and helpers for the 2-way instruction cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_cache_pkg;

    // Instruction word width seen by the CPU and carried by each refill beat
    localparam int unsigned c_WORD_W = 32;

    // One-hot controller states
    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_LOOKUP = 6'b000010,
        ST_MISS   = 6'b000100,
        ST_RECV   = 6'b001000,
        ST_REFILL = 6'b010000,
        ST_RESP   = 6'b100000
    } state_t;

    // With two ways, the least-recently-used way is always the one not just touched
    function automatic logic other_way(input logic way);
        return ~way;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_cache_way.sv
`default_nettype none
// ============================================================================
//  Module      : inst_cache_way
//  Description : One way of the cache: per-set valid bit, tag and line data.
//                Asynchronous read on index, synchronous whole-line write.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_cache_way
    import inst_cache_pkg::*;
#(
    parameter int SETS       = 8,
    parameter int LINE_WORDS = 8,
    parameter int IDX_W      = 3,
    parameter int TAG_W      = 24
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [IDX_W-1:0]                      i_idx,
    output logic                                  o_rd_valid,
    output logic [TAG_W-1:0]                      o_rd_tag,
    output logic [LINE_WORDS-1:0][c_WORD_W-1:0]   o_rd_line,
    input  logic                                  i_we,
    input  logic [TAG_W-1:0]                      i_wr_tag,
    input  logic [LINE_WORDS-1:0][c_WORD_W-1:0]   i_wr_line
);

    logic [SETS-1:0]                     r_valid;
    logic [TAG_W-1:0]                    r_tag  [SETS];
    logic [LINE_WORDS-1:0][c_WORD_W-1:0] r_data [SETS];

    // Valid bits: cleared by reset, set when a complete line is installed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_idx] <= 1'b1;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_idx]  <= i_wr_tag;
            r_data[i_idx] <= i_wr_line;
        end
    end

    assign o_rd_valid = r_valid[i_idx];
    assign o_rd_tag   = r_tag[i_idx];
    assign o_rd_line  = r_data[i_idx];

endmodule
`default_nettype wire

// File: rtl/inst_cache.sv
`default_nettype none
// ============================================================================
//  Module      : inst_cache
//  Description : 2-way set-associative read-only instruction cache. Hits
//                answer two cycles after the request; misses burst-refill a
//                full line before answering. One request in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int SETS       = 8,
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              from_cpu_req_valid,
    input  logic [ADDR_W-1:0] from_cpu_req_addr,
    output logic              to_cpu_req_ready,
    output logic              to_cpu_rsp_valid,
    output logic [31:0]       to_cpu_rsp_data,
    input  logic              from_cpu_rsp_ready,
    output logic              to_mem_rd_req_valid,
    output logic [ADDR_W-1:0] to_mem_rd_req_addr,
    input  logic              from_mem_rd_req_ready,
    input  logic              from_mem_rd_rsp_valid,
    input  logic [31:0]       from_mem_rd_rsp_data,
    input  logic              from_mem_rd_rsp_last,
    output logic              to_mem_rd_rsp_ready
);

    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int CNT_W = OFF_W - 2;

    state_t                              r_state;
    logic [ADDR_W-1:2]                   r_addr;
    logic [SETS-1:0]                     r_lru;
    logic                                r_victim;
    logic [LINE_WORDS-1:0][c_WORD_W-1:0] r_buf;
    logic [CNT_W-1:0]                    r_cnt;
    logic                                r_full;
    logic [31:0]                         r_rsp_data;
    logic                                r_req_ready;
    logic                                r_rsp_valid;
    logic                                r_mem_req_valid;
    logic                                r_mem_rsp_ready;

    logic [IDX_W-1:0]                          w_idx;
    logic [TAG_W-1:0]                          w_tag;
    logic [CNT_W-1:0]                          w_word;
    logic [1:0]                                w_way_valid;
    logic [1:0][TAG_W-1:0]                     w_way_tag;
    logic [1:0][LINE_WORDS-1:0][c_WORD_W-1:0]  w_way_line;
    logic [1:0]                                w_hit;
    logic [1:0]                                w_way_we;
    logic [31:0]                               w_hit_word;
    logic [1:0]                                w_unused_addr_lsb;

    // Byte-lane bits of the PC never select anything
    assign w_unused_addr_lsb = from_cpu_req_addr[1:0];

    assign w_idx      = r_addr[OFF_W +: IDX_W];
    assign w_tag      = r_addr[ADDR_W-1 -: TAG_W];
    assign w_word     = r_addr[2 +: CNT_W];
    assign w_hit_word = w_way_line[w_hit[1]][w_word];

    for (genvar g = 0; g < 2; g++) begin : g_way
        inst_cache_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .IDX_W      (IDX_W),
            .TAG_W      (TAG_W)
        ) u_way (
            .clk        (clk),
            .rst        (rst),
            .i_idx      (w_idx),
            .o_rd_valid (w_way_valid[g]),
            .o_rd_tag   (w_way_tag[g]),
            .o_rd_line  (w_way_line[g]),
            .i_we       (w_way_we[g]),
            .i_wr_tag   (w_tag),
            .i_wr_line  (r_buf)
        );
        assign w_hit[g]    = w_way_valid[g] && (w_way_tag[g] == w_tag);
        // A truncated burst never reaches the arrays
        assign w_way_we[g] = (r_state == ST_REFILL) && r_full && (r_victim == 1'(g));
    end

    // Controller: request acceptance, lookup, refill burst and response hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_lru           <= '0;
            r_victim        <= 1'b0;
            r_cnt           <= '0;
            r_full          <= 1'b0;
            r_rsp_data      <= '0;
            r_req_ready     <= 1'b1;
            r_rsp_valid     <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_rsp_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (from_cpu_req_valid) begin
                        r_addr      <= from_cpu_req_addr[ADDR_W-1:2];
                        r_req_ready <= 1'b0;
                        r_state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (|w_hit) begin
                        r_rsp_data   <= w_hit_word;
                        r_lru[w_idx] <= other_way(w_hit[1]);
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        // Fill an empty way before evicting anything
                        if (!w_way_valid[0]) begin
                            r_victim <= 1'b0;
                        end else if (!w_way_valid[1]) begin
                            r_victim <= 1'b1;
                        end else begin
                            r_victim <= r_lru[w_idx];
                        end
                        r_mem_req_valid <= 1'b1;
                        r_state         <= ST_MISS;
                    end
                end
                ST_MISS: begin
                    if (from_mem_rd_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                        r_rsp_data      <= '0;
                        r_mem_rsp_ready <= 1'b1;
                        r_state         <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (from_mem_rd_rsp_valid) begin
                        r_buf[r_cnt] <= from_mem_rd_rsp_data;
                        if (r_cnt == w_word) begin
                            r_rsp_data <= from_mem_rd_rsp_data;
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (from_mem_rd_rsp_last) begin
                            r_full          <= (r_cnt == CNT_W'(LINE_WORDS - 1));
                            r_mem_rsp_ready <= 1'b0;
                            r_state         <= ST_REFILL;
                        end
                    end
                end
                ST_REFILL: begin
                    if (r_full) begin
                        r_lru[w_idx] <= other_way(r_victim);
                    end
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (from_cpu_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state         <= ST_IDLE;
                    r_req_ready     <= 1'b1;
                    r_rsp_valid     <= 1'b0;
                    r_mem_req_valid <= 1'b0;
                    r_mem_rsp_ready <= 1'b0;
                end
            endcase
        end
    end

    assign to_cpu_req_ready    = r_req_ready;
    assign to_cpu_rsp_valid    = r_rsp_valid;
    assign to_cpu_rsp_data     = r_rsp_data;
    assign to_mem_rd_req_valid = r_mem_req_valid;
    assign to_mem_rd_req_addr  = {w_tag, w_idx, {OFF_W{1'b0}}};
    assign to_mem_rd_rsp_ready = r_mem_rsp_ready;

endmodule
`default_nettype wire

// File: tb/tb_inst_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_cache
//  Description : Directed self-checking bench for inst_cache. Memory returns
//                beat i of the line at address L as L + 0x100 + i.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        from_cpu_req_valid;
    logic [31:0] from_cpu_req_addr;
    logic        to_cpu_req_ready;
    logic        to_cpu_rsp_valid;
    logic [31:0] to_cpu_rsp_data;
    logic        from_cpu_rsp_ready;
    logic        to_mem_rd_req_valid;
    logic [31:0] to_mem_rd_req_addr;
    logic        from_mem_rd_req_ready;
    logic        from_mem_rd_rsp_valid;
    logic [31:0] from_mem_rd_rsp_data;
    logic        from_mem_rd_rsp_last;
    logic        to_mem_rd_rsp_ready;

    int n_cmp = 0;
    int n_err = 0;

    // Results of the most recent fetch
    logic [31:0] f_data;
    logic [31:0] f_req_addr;
    int          f_cycles;
    int          f_nreq;
    bit          f_req_stable;
    bit          f_rsp_stable;
    bit          f_aborted;

    always #5 clk = ~clk;

    inst_cache #(
        .SETS       (8),
        .LINE_WORDS (8),
        .ADDR_W     (32)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .from_cpu_req_valid    (from_cpu_req_valid),
        .from_cpu_req_addr     (from_cpu_req_addr),
        .to_cpu_req_ready      (to_cpu_req_ready),
        .to_cpu_rsp_valid      (to_cpu_rsp_valid),
        .to_cpu_rsp_data       (to_cpu_rsp_data),
        .from_cpu_rsp_ready    (from_cpu_rsp_ready),
        .to_mem_rd_req_valid   (to_mem_rd_req_valid),
        .to_mem_rd_req_addr    (to_mem_rd_req_addr),
        .from_mem_rd_req_ready (from_mem_rd_req_ready),
        .from_mem_rd_rsp_valid (from_mem_rd_rsp_valid),
        .from_mem_rd_rsp_data  (from_mem_rd_rsp_data),
        .from_mem_rd_rsp_last  (from_mem_rd_rsp_last),
        .to_mem_rd_rsp_ready   (to_mem_rd_rsp_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem_inputs();
        from_mem_rd_req_ready = 1'b0;
        from_mem_rd_rsp_valid = 1'b0;
        from_mem_rd_rsp_last  = 1'b0;
        from_mem_rd_rsp_data  = '0;
    endtask

    // One CPU fetch with a scripted memory: req_wait cycles of req back-pressure,
    // last flagged on beat last_at, optional one-cycle gaps between beats,
    // rsp_hold cycles of CPU back-pressure, and reset raised with beat rst_beat.
    task automatic fetch(input logic [31:0] a, input int req_wait, input int last_at,
                         input bit gapped, input int rsp_hold, input int rst_beat);
        int waited = 0;
        int beat   = 0;
        int lat    = 0;
        bit toggle = 1'b0;
        f_nreq = 0; f_req_stable = 1'b1; f_rsp_stable = 1'b1; f_aborted = 1'b0;
        f_req_addr = '0; f_data = '0;
        check("req_ready_before_fetch", 32'(to_cpu_req_ready), 32'd1);
        from_cpu_req_valid = 1'b1;
        from_cpu_req_addr  = a;
        tick();
        from_cpu_req_valid = 1'b0;
        from_cpu_req_addr  = '0;
        while (!to_cpu_rsp_valid && lat < 200 && !f_aborted) begin
            clear_mem_inputs();
            if (to_mem_rd_req_valid) begin
                if (waited == 0) begin
                    f_nreq++;
                    f_req_addr = to_mem_rd_req_addr;
                end else if (to_mem_rd_req_addr !== f_req_addr) begin
                    f_req_stable = 1'b0;
                end
                if (waited >= req_wait) from_mem_rd_req_ready = 1'b1;
                waited++;
            end else if (waited != 0 && waited <= req_wait) begin
                f_req_stable = 1'b0;
            end
            if (to_mem_rd_rsp_ready) begin
                toggle = !toggle;
                if (!gapped || toggle) begin
                    from_mem_rd_rsp_valid = 1'b1;
                    from_mem_rd_rsp_data  = f_req_addr + 32'h100 + 32'(beat);
                    from_mem_rd_rsp_last  = (beat == last_at);
                    if (beat == rst_beat) begin
                        rst       = 1'b1;
                        f_aborted = 1'b1;
                    end
                    beat++;
                end
            end
            tick();
            lat++;
            rst = 1'b0;
            clear_mem_inputs();
        end
        f_cycles = lat + 1;
        if (!f_aborted) begin
            check("rsp_valid_within_budget", 32'(to_cpu_rsp_valid), 32'd1);
            f_data = to_cpu_rsp_data;
            for (int i = 0; i < rsp_hold; i++) begin
                tick();
                if (!to_cpu_rsp_valid || to_cpu_rsp_data !== f_data) f_rsp_stable = 1'b0;
            end
            from_cpu_rsp_ready = 1'b1;
            tick();
            from_cpu_rsp_ready = 1'b0;
            check("rsp_handshake_to_idle", {30'd0, to_cpu_rsp_valid, to_cpu_req_ready}, 32'd1);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"},    32'(to_cpu_req_ready),    32'd1);
        check({pfx, "_rsp_valid"},    32'(to_cpu_rsp_valid),    32'd0);
        check({pfx, "_rsp_data"},     to_cpu_rsp_data,          32'd0);
        check({pfx, "_mem_req_vld"},  32'(to_mem_rd_req_valid), 32'd0);
        check({pfx, "_mem_req_addr"}, to_mem_rd_req_addr,       32'd0);
        check({pfx, "_mem_rsp_rdy"},  32'(to_mem_rd_rsp_ready), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        from_cpu_req_valid = 1'b0;
        from_cpu_req_addr  = '0;
        from_cpu_rsp_ready = 1'b0;
        clear_mem_inputs();
        repeat (3) tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Cold miss on line 0
        fetch(32'h0000_0010, 0, 7, 1'b0, 0, -1);
        check("cold_nreq",    32'(f_nreq),  32'd1);
        check("cold_addr",    f_req_addr,   32'h0000_0000);
        check("cold_data",    f_data,       32'h0000_0104);
        check("cold_latency", 32'(f_cycles), 32'd12);

        // Hit on the freshly filled line
        fetch(32'h0000_0014, 0, 7, 1'b0, 0, -1);
        check("hit_nreq",    32'(f_nreq),   32'd0);
        check("hit_latency", 32'(f_cycles), 32'd2);
        check("hit_data",    f_data,        32'h0000_0105);

        // Conflict in set 0: the third line evicts the least recently used one
        fetch(32'h0000_0100, 0, 7, 1'b0, 0, -1);
        check("conf_100_addr", f_req_addr, 32'h0000_0100);
        check("conf_100_data", f_data,     32'h0000_0200);
        fetch(32'h0000_0200, 0, 7, 1'b0, 0, -1);
        check("conf_200_nreq", 32'(f_nreq), 32'd1);
        check("conf_200_addr", f_req_addr,  32'h0000_0200);
        check("conf_200_data", f_data,      32'h0000_0300);
        fetch(32'h0000_0104, 0, 7, 1'b0, 0, -1);
        check("conf_100_hit_nreq", 32'(f_nreq), 32'd0);
        check("conf_100_hit_data", f_data,      32'h0000_0201);
        fetch(32'h0000_0000, 0, 7, 1'b0, 0, -1);
        check("conf_000_evicted_nreq", 32'(f_nreq), 32'd1);
        check("conf_000_evicted_data", f_data,      32'h0000_0100);

        // Back-pressure on the memory request and on the CPU response, gapped beats
        fetch(32'h0000_042C, 5, 7, 1'b1, 3, -1);
        check("bp_addr",       f_req_addr,          32'h0000_0420);
        check("bp_req_stable", 32'(f_req_stable),   32'd1);
        check("bp_rsp_stable", 32'(f_rsp_stable),   32'd1);
        check("bp_data",       f_data,              32'h0000_0523);
        check("bp_latency",    32'(f_cycles),       32'd24);
        fetch(32'h0000_043C, 0, 7, 1'b0, 0, -1);
        check("bp_order_nreq", 32'(f_nreq), 32'd0);
        check("bp_order_data", f_data,      32'h0000_0527);

        // Reset with beat 4 of a refill: abort, then every line is gone
        fetch(32'h0000_0640, 0, 7, 1'b0, 0, 4);
        check("rst_abort_taken", 32'(f_aborted), 32'd1);
        check_reset_outputs("midrst");
        fetch(32'h0000_042C, 0, 7, 1'b0, 0, -1);
        check("rst_refetch_nreq", 32'(f_nreq), 32'd1);
        check("rst_refetch_data", f_data,      32'h0000_0523);
        fetch(32'h0000_0640, 0, 7, 1'b0, 0, -1);
        check("rst_aborted_line_nreq", 32'(f_nreq), 32'd1);
        check("rst_aborted_line_data", f_data,      32'h0000_0740);

        // Early last: word past the end reads 0, nothing is installed
        fetch(32'h0000_0018, 0, 3, 1'b0, 0, -1);
        check("early_nreq", 32'(f_nreq), 32'd1);
        check("early_data", f_data,      32'h0000_0000);
        fetch(32'h0000_0008, 0, 3, 1'b0, 0, -1);
        check("early_again_nreq", 32'(f_nreq), 32'd1);
        check("early_recv_word",  f_data,      32'h0000_0102);
        fetch(32'h0000_0018, 0, 7, 1'b0, 0, -1);
        check("early_full_nreq", 32'(f_nreq), 32'd1);
        check("early_full_data", f_data,      32'h0000_0106);
        fetch(32'h0000_0018, 0, 7, 1'b0, 0, -1);
        check("early_then_hit_nreq", 32'(f_nreq), 32'd0);
        check("early_then_hit_data", f_data,      32'h0000_0106);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
